// File: rtl/demux_chan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demux_chan_sequencer
// Brief    : Round-robin serial-bit sequencer driving a 1:8 demux (in/sel),
//            DWELL bits per enabled channel, frame_done per completed pass.
//            Optional DEMUX_SEQ_FRAME_CNT_EN adds an 8-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module demux_chan_sequencer #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] en_mask,
   input  logic       in_valid,
   input  logic       in_data,
   output logic       in_ready,
   output logic       dmx_in,
   output logic [2:0] dmx_sel,
   output logic       dmx_vld,
   output logic       busy,
`ifdef DEMUX_SEQ_FRAME_CNT_EN
   output logic [7:0] frame_cnt,
`endif
   output logic       frame_done
);

   localparam logic [0:0] c_st_idle    = 1'b0;
   localparam logic [0:0] c_st_scan    = 1'b1;
   localparam logic [7:0] c_dwell_last = 8'(DWELL - 1);

   logic [0:0] r_state;
   logic [0:0] w_state_nxt;
   logic [7:0] r_act_mask;
   logic [2:0] r_chan;
   logic [7:0] r_dwell;
   logic       r_stop;

   logic       w_busy;
   logic       w_xfer;
   logic       w_last;
   logic       w_has_up;
   logic       w_wrap;
   logic       w_start_ok;
   logic       w_to_idle;
   logic [2:0] w_next_up;
   logic [2:0] w_first_new;

   // Descending scans leave the lowest qualifying index in each result.
   always_comb begin
      w_next_up   = 3'd0;
      w_has_up    = 1'b0;
      w_first_new = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_act_mask[i] && (i > int'(r_chan))) begin
            w_next_up = 3'(i);
            w_has_up  = 1'b1;
         end
         if (en_mask[i]) begin
            w_first_new = 3'(i);
         end
      end
   end

   assign w_busy     = (r_state == c_st_scan);
   assign w_xfer     = w_busy && in_valid;
   assign w_last     = w_xfer && (r_dwell == c_dwell_last);
   assign w_wrap     = w_last && !w_has_up;
   assign w_start_ok = start && !stop && (en_mask != 8'h00);
   // A stop arriving on the channel's final transfer still ends the scan there.
   assign w_to_idle  = w_last && (r_stop || stop || (w_wrap && (en_mask == 8'h00)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (w_start_ok) w_state_nxt = c_st_scan;
         c_st_scan: if (w_to_idle)  w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      busy     = w_busy;
      in_ready = w_busy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act_mask <= 8'h00;
         r_chan     <= 3'd0;
         r_dwell    <= 8'd0;
         r_stop     <= 1'b0;
         dmx_vld    <= 1'b0;
         dmx_in     <= 1'b0;
         dmx_sel    <= 3'd0;
         frame_done <= 1'b0;
      end else begin
         dmx_vld    <= w_xfer;
         dmx_in     <= w_xfer & in_data;
         frame_done <= w_wrap;
         if (w_xfer) begin
            dmx_sel <= r_chan;
         end
         if (!w_busy) begin
            if (w_start_ok) begin
               r_act_mask <= en_mask;
               r_chan     <= w_first_new;
               r_dwell    <= 8'd0;
               r_stop     <= 1'b0;
            end
         end else begin
            if (stop) begin
               r_stop <= 1'b1;
            end
            if (w_xfer) begin
               if (w_last) begin
                  r_dwell <= 8'd0;
                  if (w_wrap) begin
                     r_act_mask <= en_mask;
                     r_chan     <= w_first_new;
                  end else begin
                     r_chan <= w_next_up;
                  end
               end else begin
                  r_dwell <= r_dwell + 8'd1;
               end
            end
            if (w_to_idle) begin
               r_stop <= 1'b0;
            end
         end
      end
   end

`ifdef DEMUX_SEQ_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= 8'd0;
      end else if (w_wrap) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`else
   // Frame counter not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_chan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_chan_sequencer
// Brief    : Self-checking bench; three DUTs (DWELL=2,3,4) share stimulus and
//            are compared every cycle against a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_chan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] en_mask = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_data = 1'b0;

   logic       rdy  [3];
   logic       din  [3];
   logic [2:0] sel  [3];
   logic       vld  [3];
   logic       bsy  [3];
   logic       fd   [3];
   logic [7:0] fcnt [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      demux_chan_sequencer #(.DWELL(k + 2)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start),
         .stop       (stop),
         .en_mask    (en_mask),
         .in_valid   (in_valid),
         .in_data    (in_data),
         .in_ready   (rdy[k]),
         .dmx_in     (din[k]),
         .dmx_sel    (sel[k]),
         .dmx_vld    (vld[k]),
         .busy       (bsy[k]),
`ifdef DEMUX_SEQ_FRAME_CNT_EN
         .frame_cnt  (fcnt[k]),
`endif
         .frame_done (fd[k])
      );
   end

`ifndef DEMUX_SEQ_FRAME_CNT_EN
   initial for (int k = 0; k < 3; k++) fcnt[k] = 8'd0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model state: one entry per DUT, DWELL = index + 2.
   bit         m_busy [3];
   logic [7:0] m_mask [3];
   int         m_chan [3];
   int         m_cnt  [3];
   bit         m_stop [3];
   bit         e_vld  [3];
   bit         e_in   [3];
   bit         e_fd   [3];
   logic [2:0] e_sel  [3];
   logic [7:0] e_fcnt [3];
   logic [4:0] q0[$], q1[$], q2[$];

   function automatic int lowest(input logic [7:0] m);
      for (int i = 0; i < 8; i++) if (m[i]) return i;
      return 0;
   endfunction

   task automatic model_step(input int k);
      int  nxt;
      bit  found;
      bit  stp;
      if (rst) begin
         m_busy[k] = 0; m_mask[k] = 8'h00; m_chan[k] = 0; m_cnt[k] = 0; m_stop[k] = 0;
         e_vld[k] = 0; e_in[k] = 0; e_fd[k] = 0; e_sel[k] = 3'd0; e_fcnt[k] = 8'd0;
         return;
      end
      e_vld[k] = 0; e_in[k] = 0; e_fd[k] = 0;
      if (!m_busy[k]) begin
         if (start && !stop && en_mask != 8'h00) begin
            m_busy[k] = 1; m_mask[k] = en_mask; m_chan[k] = lowest(en_mask);
            m_cnt[k] = 0; m_stop[k] = 0;
         end
         return;
      end
      stp = m_stop[k] | stop;
      m_stop[k] = stp;
      if (!in_valid) return;
      e_vld[k] = 1; e_in[k] = in_data; e_sel[k] = 3'(m_chan[k]);
      m_cnt[k]++;
      if (m_cnt[k] == k + 2) begin
         m_cnt[k] = 0;
         nxt = m_chan[k];
         found = 0;
         for (int off = 1; off <= 8; off++) begin
            if (!found && m_mask[k][(m_chan[k] + off) % 8]) begin
               nxt = (m_chan[k] + off) % 8;
               found = 1;
            end
         end
         if (nxt <= m_chan[k]) begin
            e_fd[k] = 1;
            e_fcnt[k] = e_fcnt[k] + 8'd1;
            m_mask[k] = en_mask;
            nxt = lowest(en_mask);
            if (en_mask == 8'h00) m_busy[k] = 0;
         end
         if (stp) m_busy[k] = 0;
         if (!m_busy[k]) m_stop[k] = 0;
         m_chan[k] = nxt;
      end
   endtask

   // Compare process: advance the model on each edge, check #1 later.
   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            model_step(k);
            if (e_vld[k]) begin
               case (k)
                  0: q0.push_back({e_sel[k], e_in[k], e_fd[k]});
                  1: q1.push_back({e_sel[k], e_in[k], e_fd[k]});
                  default: q2.push_back({e_sel[k], e_in[k], e_fd[k]});
               endcase
            end
         end
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d dmx_vld", k + 2), 32'(vld[k]), 32'(e_vld[k]));
            chk($sformatf("d%0d dmx_in", k + 2), 32'(din[k]), 32'(e_in[k]));
            chk($sformatf("d%0d dmx_sel", k + 2), 32'(sel[k]), 32'(e_sel[k]));
            chk($sformatf("d%0d frame_done", k + 2), 32'(fd[k]), 32'(e_fd[k]));
            chk($sformatf("d%0d busy", k + 2), 32'(bsy[k]), 32'(m_busy[k]));
            chk($sformatf("d%0d in_ready", k + 2), 32'(rdy[k]), 32'(m_busy[k]));
`ifdef DEMUX_SEQ_FRAME_CNT_EN
            chk($sformatf("d%0d frame_cnt", k + 2), 32'(fcnt[k]), 32'(e_fcnt[k]));
`endif
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic all_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s d%0d vld", tag, k + 2), 32'(vld[k]), 32'd0);
         chk($sformatf("%s d%0d in", tag, k + 2), 32'(din[k]), 32'd0);
         chk($sformatf("%s d%0d sel", tag, k + 2), 32'(sel[k]), 32'd0);
         chk($sformatf("%s d%0d busy", tag, k + 2), 32'(bsy[k]), 32'd0);
         chk($sformatf("%s d%0d rdy", tag, k + 2), 32'(rdy[k]), 32'd0);
         chk($sformatf("%s d%0d fd", tag, k + 2), 32'(fd[k]), 32'd0);
      end
   endtask

   int t1d[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
   int t1s[8] = '{0, 0, 2, 2, 5, 5, 7, 7};
   int t5s[10] = '{0, 0, 1, 1, 7, 7, 7, 7, 7, 7};

   initial begin
      // Reset state
      rst = 1'b1;
      cyc(); cyc();
      all_zero("reset");
      rst = 1'b0;

      // DWELL=2, mask A5: four channels, one pass
      q0.delete(); q1.delete(); q2.delete();
      en_mask = 8'hA5; start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = t1d[i][0]; cyc();
      end
      in_valid = 1'b0; cyc();
      chk("t1 count", 32'(q0.size()), 32'd8);
      for (int i = 0; i < 8 && i < q0.size(); i++)
         chk($sformatf("t1 bit%0d", i), 32'(q0[i]), 32'({3'(t1s[i]), t1d[i][0], (i == 7)}));

      // DWELL=4, single channel 4, 12 transfers
      rst = 1'b1; cyc(); rst = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      en_mask = 8'h10; start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = i[0]; cyc();
      end
      in_valid = 1'b0; cyc();
      chk("t2 count", 32'(q2.size()), 32'd12);
      for (int i = 0; i < 12 && i < q2.size(); i++)
         chk($sformatf("t2 bit%0d", i), 32'(q2[i]), 32'({3'd4, i[0], (i % 4 == 3)}));

      // Gapped valid: dwell counts transfers only
      q0.delete(); q1.delete(); q2.delete();
      for (int i = 0; i < 8; i++) begin
         in_valid = ~i[0]; in_data = 1'b1; cyc();
      end
      in_valid = 1'b0; cyc();
      chk("t3 count", 32'(q2.size()), 32'd4);
      for (int i = 0; i < 4 && i < q2.size(); i++)
         chk($sformatf("t3 bit%0d", i), 32'(q2[i]), 32'({3'd4, 1'b1, (i == 3)}));

      // DWELL=3, mask 0C, stop after first transfer of channel 2
      rst = 1'b1; cyc(); rst = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      en_mask = 8'h0C; start = 1'b1; cyc(); start = 1'b0;
      in_valid = 1'b1; in_data = 1'b1; cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      cyc(); cyc(); cyc();
      in_valid = 1'b0;
      chk("t4 count", 32'(q1.size()), 32'd3);
      for (int i = 0; i < 3 && i < q1.size(); i++)
         chk($sformatf("t4 bit%0d", i), 32'(q1[i]), 32'({3'd2, 1'b1, 1'b0}));
      chk("t4 busy", 32'(bsy[1]), 32'd0);
      chk("t4 in_ready", 32'(rdy[1]), 32'd0);

      // DWELL=2, mask 03 changed to 80 mid-pass
      rst = 1'b1; cyc(); rst = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      en_mask = 8'h03; start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) en_mask = 8'h80;
         in_valid = 1'b1; in_data = i[0]; cyc();
      end
      in_valid = 1'b0; cyc();
      chk("t5 count", 32'(q0.size()), 32'd10);
      for (int i = 0; i < 10 && i < q0.size(); i++)
         chk($sformatf("t5 bit%0d", i), 32'(q0[i]),
             32'({3'(t5s[i]), i[0], (i == 3 || i == 5 || i == 7 || i == 9)}));
`ifdef DEMUX_SEQ_FRAME_CNT_EN
      chk("t5 frame_cnt", 32'(fcnt[0]), 32'd4);
`endif

      // Reset mid-channel, then start with empty mask
      in_valid = 1'b1; in_data = 1'b1; cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      all_zero("midrst");
`ifdef DEMUX_SEQ_FRAME_CNT_EN
      chk("midrst frame_cnt", 32'(fcnt[0]), 32'd0);
`endif
      en_mask = 8'h00; start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc();
      all_zero("mask0");

      // start together with stop in IDLE is ignored
      en_mask = 8'h05; start = 1'b1; stop = 1'b1; cyc();
      start = 1'b0; stop = 1'b0; cyc();
      for (int k = 0; k < 3; k++)
         chk($sformatf("startstop d%0d busy", k + 2), 32'(bsy[k]), 32'd0);
      in_valid = 1'b0; cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demux_chan_sequencer.md
# demux_chan_sequencer

Upstream sequencer for the 1:8 demultiplexer. It accepts a serial bit stream over a valid/ready handshake and drives the demux data input and 3-bit select. Each enabled channel receives a fixed burst of DWELL bits, then the select moves to the next enabled channel in round-robin order. A frame-done pulse marks each completed pass over the enabled channels.

## Interface
- DWELL, default 4: bits delivered per channel visit; legal range 1..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin scanning; sampled only in IDLE.
- stop  input  1  request to end scanning; sampled only in SCAN.
- en_mask  input  8  channel enable mask; bit n enables demux output n.
- in_valid  input  1  upstream bit valid.
- in_data  input  1  upstream serial bit.
- in_ready  output  1  block accepts a bit this cycle.
- dmx_in  output  1  registered data bit to the demux `in`.
- dmx_sel  output  3  registered select to the demux `sel`.
- dmx_vld  output  1  dmx_in/dmx_sel carry a delivered bit this cycle.
- busy  output  1  high in SCAN.
- frame_done  output  1  one-cycle pulse at the end of each full pass.

## Operation
- Reset values: in_ready=0, dmx_in=0, dmx_sel=0, dmx_vld=0, busy=0, frame_done=0. Internal state is IDLE, and all counters and the stop flag are cleared.
- The FSM has two states, IDLE and SCAN.
- IDLE → SCAN when start=1 and en_mask≠0.
  - The mask is latched into act_mask.
  - The channel is set to the lowest set bit of act_mask, and the dwell counter is cleared.
- start with en_mask=0 is ignored. start and stop in the same IDLE cycle also leaves the FSM in IDLE.
- In SCAN, in_ready=1. A transfer occurs when in_valid and in_ready are both 1.
- Each transfer increments the dwell counter.
- On the DWELL-th transfer of a channel:
  - The counter clears.
  - The channel advances to the next higher set bit of act_mask, wrapping 7→0.
- Wrap rule: when the next enabled channel is numerically ≤ the current channel, the pass is complete.
  - frame_done pulses.
  - act_mask is re-latched from the current en_mask. The next channel is the lowest set bit of the new mask.
  - If the new mask is 0, the FSM goes to IDLE.
- A single enabled channel wraps onto itself and pulses frame_done every DWELL transfers.
- stop in SCAN sets a pending flag. The current channel still receives its remaining transfers. On that channel's final transfer the FSM goes to IDLE, and frame_done pulses only if that transfer also completed a pass.
- in_valid with no transfer: no state change, dmx_vld=0 next cycle.
- start in SCAN is ignored. Changes to en_mask mid-pass have no effect until the next wrap.
- dmx_in is forced to 0 whenever dmx_vld=0. dmx_sel holds its last value.

## Timing
- Latency: a transfer in cycle t gives dmx_vld=1, dmx_in=in_data, and dmx_sel=the channel of that transfer at cycle t+1.
- frame_done is asserted at t+1, aligned with the dmx_vld of the final transfer of the pass.
- busy rises the cycle after start is accepted. It falls the cycle after the last transfer before IDLE.
- in_ready follows busy; it is 0 in the cycle after returning to IDLE.
- Throughput: one bit per cycle, with no bubbles at channel changes or wraps.
- rst mid-scan: all outputs return to their reset values at the next edge. Any in-flight bit is dropped.

## Configuration
- DEMUX_SEQ_FRAME_CNT_EN defined:
  - An extra output frame_cnt (8 bits, reset 0) is present.
  - It increments, wrapping 255→0, in the same cycle that frame_done is asserted.
  - It holds its value in IDLE and clears only on rst.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- DWELL=2, en_mask=8'b1010_0101, start, in_valid held at 1, data 1,0,1,1,0,0,1,0 → dmx_sel 0,0,2,2,5,5,7,7. dmx_in follows the data, with one-cycle latency. frame_done is 1 only alongside the 8th dmx_vld.
- DWELL=4, en_mask=8'h10, 12 transfers → dmx_sel stays 4. frame_done pulses on the 4th, 8th and 12th delivered bits.
- in_valid toggling 1,0,1,0 during SCAN → dmx_vld mirrors it one cycle later, with dmx_in=0 in idle gaps. The dwell counter counts transfers only.
- stop asserted after the 1st transfer of channel 2 (DWELL=3, mask 8'h0C) → 2 more bits delivered on sel=2, then busy=0 and in_ready=0. No frame_done.
- en_mask changed from 8'h03 to 8'h80 mid-pass → the current pass finishes on channels 0 and 1, then all subsequent bits go to sel=7. With DEMUX_SEQ_FRAME_CNT_EN defined, frame_cnt counts 1,2,…
- rst pulsed mid-channel, then start with en_mask=0 → all outputs 0 after the reset edge. The FSM stays in IDLE and in_ready=0.
